// File: rtl/ram_ctrl.sv
// Single-port word RAM controller: wait states, request/ready handshake, byte-lane writes
// and out-of-range detection. Optional per-word even parity when RAM_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a read or write request
// WAIT   | down-counting WAIT_STATES before the array access
// ACCESS | array read or merged write using the latched request
// DONE   | mem_ready pulse; addr_err / parity_err valid
module ram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     BusMuxOut,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     MDataIn,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  addr_err,
    output logic                  parity_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                aerr_q, aerr_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic [DATA_W-1:0]   wmerge;

    assign idx      = addr_q[IDX_W-1:0];
    assign in_range = {{(32-ADDR_W){1'b0}}, addr_q} < 32'(DEPTH);

`ifdef RAM_PARITY_EN
    logic                par [DEPTH];
    logic                perr_q, perr_d;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // Lanes without an enable keep the stored byte.
    always_comb begin
        wmerge = mem[idx];
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) wmerge[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        aerr_d  = 1'b0;
`ifdef RAM_PARITY_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (write || read) begin
                    addr_d  = addr;
                    wdata_d = BusMuxOut;
                    be_d    = byte_en;
                    we_d    = write;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = DONE;
                ready_d = 1'b1;
                aerr_d  = !in_range;
                if (!we_q) begin
                    rdata_d = in_range ? mem[idx] : '0;
`ifdef RAM_PARITY_EN
                    perr_d  = in_range && ((^mem[idx]) != par[idx]);
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            aerr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RAM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            aerr_q  <= aerr_d;
            busy_q  <= busy_d;
`ifdef RAM_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Array is never cleared; a clear on the ACCESS edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!clear && state_q == ACCESS && we_q && in_range) begin
            mem[idx] <= wmerge;
`ifdef RAM_PARITY_EN
            par[idx] <= ^wmerge;
`endif
        end
    end

    assign MDataIn   = rdata_q;
    assign mem_ready = ready_q;
    assign addr_err  = aerr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: random and directed requests on a WAIT_STATES=1 / DEPTH=256
// instance plus a directed WAIT_STATES=3 instance for latency and clear-abort behaviour.
`timescale 1ns/1ps
module tb_ram_ctrl;
    localparam int DW = 32, AW = 9, DEPTH = 256, WS = 1, WS3 = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          clear, read, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    be;
    logic          ready, busy, aerr, perr;

    logic          b_clear, b_read, b_write;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [3:0]    b_be;
    logic          b_ready, b_busy, b_aerr, b_perr;

    ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clock(clock), .clear(clear), .read(read), .write(write), .addr(addr),
        .BusMuxOut(wdata), .byte_en(be), .MDataIn(rdata), .mem_ready(ready),
        .busy(busy), .addr_err(aerr), .parity_err(perr));

    ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .WAIT_STATES(WS3)) u_dut3 (
        .clock(clock), .clear(b_clear), .read(b_read), .write(b_write), .addr(b_addr),
        .BusMuxOut(b_wdata), .byte_en(b_be), .MDataIn(b_rdata), .mem_ready(b_ready),
        .busy(b_busy), .addr_err(b_aerr), .parity_err(b_perr));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        ae;
        logic        pe;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = 32'h0;

    // Monitor: every mem_ready pulse pops one expected response.
    always @(negedge clock) begin
        if (ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'(ready), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.rd);
                chk("addr_err", 32'(aerr), 32'(e.ae));
                chk("parity_err", 32'(perr), 32'(e.pe));
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (aerr || perr) begin
            chk("err_without_ready", {30'h0, aerr, perr}, 32'h0);
        end
    end

    // Issue one request at a negedge; inputs are scrambled right after acceptance.
    task automatic issue(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic dup, input logic exp_pe);
        exp_t e;
        read = r; write = w; addr = a; wdata = d; be = b;
        if (w) begin
            if (a < DEPTH)
                for (int i = 0; i < 4; i++)
                    if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end else begin
            last_rd = (a < DEPTH) ? model[a] : 32'h0;
        end
        e.rd = last_rd; e.ae = (a >= DEPTH); e.pe = exp_pe; e.cyc = cyc + WS + 2;
        sb.push_back(e);
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        addr = AW'($urandom); wdata = $urandom; be = 4'($urandom);
        chk("busy_high", 32'(busy), 32'h1);
        for (int k = 0; k < WS + 2; k++) begin
            @(negedge clock);
            if (dup && k == WS) read = 1'b1;
            if (k == WS + 1) read = 1'b0;
        end
        chk("busy_idle", 32'(busy), 32'h0);
    endtask

    task automatic b_req(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
        int n;
        n = cyc;
        b_read = !w; b_write = w; b_addr = a; b_wdata = d; b_be = 4'hF;
        @(negedge clock);
        b_read = 1'b0; b_write = 1'b0; b_addr = AW'($urandom); b_wdata = $urandom;
        lat = -1; rd = 'x;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (b_ready && lat < 0) begin
                lat = cyc - n;
                rd  = b_rdata;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, nrdy, n;

        clear = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; be = '0;
        b_clear = 1'b1; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        repeat (3) @(negedge clock);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_aerr", 32'(aerr), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        clear = 1'b0; b_clear = 1'b0;
        @(negedge clock);

        for (int a = 0; a < DEPTH; a++) issue(1'b1, 1'b0, AW'(a), $urandom, 4'hF, 1'b0, 1'b0);

        issue(1'b1, 1'b0, 9'd3, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 9'd3, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 9'd3, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("tp1_rdata", rdata, 32'hDEADBEEF);

        issue(1'b1, 1'b0, 9'd5, 32'h11223344, 4'hF, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 9'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 9'd5, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("tp2_merge", rdata, 32'h11BB33DD);

        issue(1'b0, 1'b1, 9'd300, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("tp3_oor_read", rdata, 32'h0);
        issue(1'b1, 1'b0, 9'd44, 32'h64, 4'hF, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 9'd300, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 9'd44, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("tp3_unchanged", rdata, 32'h64);

        issue(1'b1, 1'b1, 9'd10, 32'h5, 4'hF, 1'b1, 1'b0);
        chk("tp4_hold", rdata, 32'h64);
        issue(1'b0, 1'b1, 9'd10, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("tp4_written", rdata, 32'h5);
        issue(1'b1, 1'b0, 9'd3, 32'h0BADF00D, 4'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 9'd3, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("be_zero", rdata, 32'hDEADBEEF);

        // clear coinciding with the ACCESS edge: no write, no ready
        read = 1'b0; write = 1'b1; addr = 9'd3; wdata = 32'h0; be = 4'hF;
        @(negedge clock);
        write = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        last_rd = 32'h0;
        chk("clr_rdata", rdata, 32'h0);
        chk("clr_ready", 32'(ready), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clock);
        issue(1'b0, 1'b1, 9'd3, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("clr_no_write", rdata, 32'hDEADBEEF);

        for (int t = 0; t < 300; t++) begin
            logic w, r;
            w = 1'($urandom);
            r = !w || ($urandom_range(0, 3) == 0);
            issue(w, r, AW'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

`ifdef RAM_PARITY_EN
        issue(1'b1, 1'b0, 9'd7, 32'h1, 4'hF, 1'b0, 1'b0);
        u_dut.mem[7][0] = ~u_dut.mem[7][0];
        model[7] = 32'h0;
        issue(1'b0, 1'b1, 9'd7, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("par_rdata", rdata, 32'h0);
`endif

        b_req(1'b1, 9'd20, 32'hCAFEF00D, rd, lat);
        chk("ws3_wr_latency", 32'(lat), 32'(WS3 + 2));
        b_req(1'b0, 9'd20, 32'h0, rd, lat);
        chk("ws3_rd_latency", 32'(lat), 32'(WS3 + 2));
        chk("ws3_rdata", rd, 32'hCAFEF00D);

        n = cyc;
        b_write = 1'b1; b_addr = 9'd20; b_wdata = 32'h12345678; b_be = 4'hF;
        @(negedge clock);
        b_write = 1'b0;
        @(negedge clock);
        b_clear = 1'b1;
        @(negedge clock);
        b_clear = 1'b0;
        chk("ws3_clr_cycle", 32'(cyc - n), 32'h3);
        chk("ws3_clr_rdata", b_rdata, 32'h0);
        chk("ws3_clr_ready", 32'(b_ready), 32'h0);
        chk("ws3_clr_busy", 32'(b_busy), 32'h0);
        chk("ws3_clr_aerr", 32'(b_aerr), 32'h0);
        nrdy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (b_ready) nrdy++;
        end
        chk("ws3_no_ready", 32'(nrdy), 32'h0);
        b_req(1'b0, 9'd20, 32'h0, rd, lat);
        chk("ws3_old_value", rd, 32'hCAFEF00D);
        chk("ws3_perr", 32'(b_perr), 32'h0);

        repeat (5) @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end
endmodule
